// File: rtl/arm_alu_v1.sv
// arm_alu_v1: 32-bit ARM-style execute-stage ALU.
// Covers the 16 data-processing opcodes (flag-setting) and nine internal
// address/pass-through micro-ops (flags held). Result and flags are
// registered, giving one clock of latency and full issue rate.
module arm_alu_v1 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic [4:0]       OP,
   output logic [WIDTH-1:0] R,
   output logic [3:0]       FLAG
);

   localparam int unsigned MSB = WIDTH - 1;

   // Data-processing opcodes (OP[4]=0)
   localparam logic [4:0] OP_AND = 5'b00000;
   localparam logic [4:0] OP_EOR = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_RSB = 5'b00011;
   localparam logic [4:0] OP_ADD = 5'b00100;
   localparam logic [4:0] OP_ADC = 5'b00101;
   localparam logic [4:0] OP_SBC = 5'b00110;
   localparam logic [4:0] OP_RSC = 5'b00111;
   localparam logic [4:0] OP_TST = 5'b01000;
   localparam logic [4:0] OP_TEQ = 5'b01001;
   localparam logic [4:0] OP_CMP = 5'b01010;
   localparam logic [4:0] OP_CMN = 5'b01011;
   localparam logic [4:0] OP_ORR = 5'b01100;
   localparam logic [4:0] OP_MOV = 5'b01101;
   localparam logic [4:0] OP_BIC = 5'b01110;
   localparam logic [4:0] OP_MVN = 5'b01111;

   // Internal micro-ops (OP[4]=1); flags are never touched
   localparam logic [4:0] OP_PASS_B   = 5'b10000;
   localparam logic [4:0] OP_B_P4     = 5'b10001;
   localparam logic [4:0] OP_A_B_P4   = 5'b10010;
   localparam logic [4:0] OP_B_M4     = 5'b10011;
   localparam logic [4:0] OP_A_M4     = 5'b10100;
   localparam logic [4:0] OP_A_P_B    = 5'b10101;
   localparam logic [4:0] OP_B_M_A    = 5'b10110;
   localparam logic [4:0] OP_PASS_A   = 5'b11001;
   localparam logic [4:0] OP_A_P4     = 5'b11010;

   localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

   // Shared adder: every flag-setting arithmetic op is x + y + cin,
   // with y already inverted for the subtract forms.
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;

   logic [WIDTH-1:0] w_res;
   logic             w_arith;
   logic             w_flag_we;

   logic             w_z;
   logic             w_n;
   logic             w_v;
   logic             w_c;
   logic [3:0]       w_flag_nxt;

   logic [WIDTH-1:0] r_res;
   logic [3:0]       r_flag;

   // 33-bit sum so the carry out of bit 31 is available directly
   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + (WIDTH+1)'(w_cin);

   // Opcode decode: select adder operands, result source and flag update
   always_comb begin
      w_x       = A;
      w_y       = B;
      w_cin     = 1'b0;
      w_res     = '0;
      w_arith   = 1'b0;
      w_flag_we = 1'b0;

      unique case (OP)
         OP_AND, OP_TST: begin
            w_res     = A & B;
            w_flag_we = 1'b1;
         end
         OP_EOR, OP_TEQ: begin
            w_res     = A ^ B;
            w_flag_we = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            w_x       = A;
            w_y       = ~B;
            w_cin     = 1'b1;
            w_res     = w_sum[MSB:0];
            w_arith   = 1'b1;
            w_flag_we = 1'b1;
         end
         OP_RSB: begin
            w_x       = B;
            w_y       = ~A;
            w_cin     = 1'b1;
            w_res     = w_sum[MSB:0];
            w_arith   = 1'b1;
            w_flag_we = 1'b1;
         end
         OP_ADD, OP_CMN: begin
            w_res     = w_sum[MSB:0];
            w_arith   = 1'b1;
            w_flag_we = 1'b1;
         end
         OP_ADC: begin
            w_cin     = CIN;
            w_res     = w_sum[MSB:0];
            w_arith   = 1'b1;
            w_flag_we = 1'b1;
         end
         OP_SBC: begin
            w_x       = A;
            w_y       = ~B;
            w_cin     = CIN;
            w_res     = w_sum[MSB:0];
            w_arith   = 1'b1;
            w_flag_we = 1'b1;
         end
         OP_RSC: begin
            w_x       = B;
            w_y       = ~A;
            w_cin     = CIN;
            w_res     = w_sum[MSB:0];
            w_arith   = 1'b1;
            w_flag_we = 1'b1;
         end
         OP_ORR: begin
            w_res     = A | B;
            w_flag_we = 1'b1;
         end
         OP_MOV: begin
            w_res     = B;
            w_flag_we = 1'b1;
         end
         OP_BIC: begin
            w_res     = A & ~B;
            w_flag_we = 1'b1;
         end
         OP_MVN: begin
            w_res     = ~B;
            w_flag_we = 1'b1;
         end
         OP_PASS_B: w_res = B;
         OP_B_P4:   w_res = B + FOUR;
         OP_A_B_P4: w_res = A + B + FOUR;
         OP_B_M4:   w_res = B - FOUR;
         OP_A_M4:   w_res = A - FOUR;
         OP_A_P_B:  w_res = A + B;
         OP_B_M_A:  w_res = B - A;
         OP_PASS_A: w_res = A;
         OP_A_P4:   w_res = A + FOUR;
         default: begin
            // Undefined codes: zero result, flags hold
            w_res     = '0;
            w_flag_we = 1'b0;
         end
      endcase
   end

   // Condition codes; V compares against the actual adder operands, which
   // covers both the add rule and the minuend-based subtract rule.
   always_comb begin
      w_z = (w_res == '0);
      w_n = w_res[MSB];
      if (w_arith) begin
         w_c = w_sum[WIDTH];
         w_v = (w_x[MSB] == w_y[MSB]) && (w_res[MSB] != w_x[MSB]);
      end else begin
         w_c = CIN;
         w_v = 1'b0;
      end
      w_flag_nxt = {w_z, w_n, w_v, w_c};
   end

   // Result and status registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_res  <= '0;
         r_flag <= '0;
      end else begin
         r_res <= w_res;
         if (w_flag_we) begin
            r_flag <= w_flag_nxt;
         end
      end
   end

   assign R    = r_res;
   assign FLAG = r_flag;

endmodule

// File: tb/tb_arm_alu_v1.sv
// tb_arm_alu_v1: directed and randomized checks of arm_alu_v1 against a
// behavioural model using wide integer arithmetic.
`timescale 1ns/1ps
module tb_arm_alu_v1;

   logic        clk;
   logic        reset_n;
   logic [31:0] A;
   logic [31:0] B;
   logic        CIN;
   logic [4:0]  OP;
   logic [31:0] R;
   logic [3:0]  FLAG;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [3:0]  m_flag;   // model status register
   logic [31:0] m_res;

   arm_alu_v1 #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A       (A),
      .B       (B),
      .CIN     (CIN),
      .OP      (OP),
      .R       (R),
      .FLAG    (FLAG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time bound so the run cannot hang
   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%08h required=%08h", tag, act, exp);
      end
   endtask

   // x + y + cin with carry from unsigned width and overflow from signed range
   task automatic m_add(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        output logic [31:0] r, output logic c, output logic v);
      longint ux, uy, full, sx, sy, sv;
      ux = {32'd0, x}; uy = {32'd0, y};
      sx = $signed(x); sy = $signed(y);
      full = ux + uy + longint'(ci);
      sv   = sx + sy + longint'(ci);
      r = full[31:0];
      c = (full > 64'sd4294967295);
      v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
   endtask

   // x - y - borrow; carry means no borrow occurred
   task automatic m_sub(input logic [31:0] x, input logic [31:0] y, input logic bw,
                        output logic [31:0] r, output logic c, output logic v);
      longint ux, uy, full, sx, sy, sv;
      ux = {32'd0, x}; uy = {32'd0, y};
      sx = $signed(x); sy = $signed(y);
      full = ux - uy - longint'(bw);
      sv   = sx - sy - longint'(bw);
      r = full[31:0];
      c = (ux >= uy + longint'(bw));
      v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
   endtask

   // Reference: updates m_res and m_flag for one operation
   task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ci);
      logic [31:0] r;
      logic c, v, setf;
      r = 32'd0; c = ci; v = 1'b0; setf = 1'b1;
      case (op)
         5'd0, 5'd8:  r = a & b;
         5'd1, 5'd9:  r = a ^ b;
         5'd2, 5'd10: m_sub(a, b, 1'b0, r, c, v);
         5'd3:        m_sub(b, a, 1'b0, r, c, v);
         5'd4, 5'd11: m_add(a, b, 1'b0, r, c, v);
         5'd5:        m_add(a, b, ci, r, c, v);
         5'd6:        m_sub(a, b, ~ci, r, c, v);
         5'd7:        m_sub(b, a, ~ci, r, c, v);
         5'd12:       r = a | b;
         5'd13:       r = b;
         5'd14:       r = a & ~b;
         5'd15:       r = ~b;
         5'd16: begin r = b;            setf = 1'b0; end
         5'd17: begin r = b + 32'd4;    setf = 1'b0; end
         5'd18: begin r = a + b + 32'd4; setf = 1'b0; end
         5'd19: begin r = b - 32'd4;    setf = 1'b0; end
         5'd20: begin r = a - 32'd4;    setf = 1'b0; end
         5'd21: begin r = a + b;        setf = 1'b0; end
         5'd22: begin r = b - a;        setf = 1'b0; end
         5'd25: begin r = a;            setf = 1'b0; end
         5'd26: begin r = a + 32'd4;    setf = 1'b0; end
         default: begin r = 32'd0;      setf = 1'b0; end
      endcase
      m_res = r;
      if (setf) m_flag = {(r == 32'd0), r[31], v, c};
   endtask

   // Drive one op mid-cycle, check both outputs just after the next edge
   task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ci);
      @(negedge clk);
      OP = op; A = a; B = b; CIN = ci;
      model(op, a, b, ci);
      @(posedge clk);
      #1;
      check({tag, ".R"}, R, m_res);
      check({tag, ".FLAG"}, {28'd0, FLAG}, {28'd0, m_flag});
   endtask

   // Directed expectation, written out independently of the model
   task automatic dstep(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ci,
                        input logic [31:0] exp_r, input logic [3:0] exp_f);
      step(tag, op, a, b, ci);
      check({tag, ".Rk"}, R, exp_r);
      check({tag, ".Fk"}, {28'd0, FLAG}, {28'd0, exp_f});
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] edges [6];
      edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h8000_0000;
      edges[3] = 32'h7FFF_FFFF; edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h0000_0003;
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return $urandom();
   endfunction

   initial begin
      reset_n = 1'b0;
      A = 32'h0; B = 32'h0; CIN = 1'b0; OP = 5'd0;
      m_flag = 4'd0; m_res = 32'd0;

      // Reset held while clock runs with arbitrary inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         A = $urandom(); B = $urandom(); CIN = 1'($urandom()); OP = 5'($urandom());
         @(posedge clk); #1;
         check("rst.R", R, 32'd0);
         check("rst.FLAG", {28'd0, FLAG}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;

      dstep("add",  5'd4,  32'h7F00_0000, 32'h0F00_1000, 1'b0, 32'h8E00_1000, 4'b0110);
      dstep("sub",  5'd2,  32'h5000_0000, 32'hB000_0000, 1'b0, 32'hA000_0000, 4'b0110);
      dstep("and",  5'd0,  32'h1234_4567, 32'h0000_FE18, 1'b0, 32'h0000_4400, 4'b0000);
      dstep("movz", 5'd13, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b1000);
      dstep("adc",  5'd5,  32'h5000_0000, 32'hB000_0000, 1'b1, 32'h0000_0001, 4'b0001);
      dstep("sbc",  5'd6,  32'h005A_C023, 32'h0DAE_2310, 1'b0, 32'hF2AC_9D12, 4'b0100);
      dstep("rsc",  5'd7,  32'h0000_0001, 32'h0000_0005, 1'b1, 32'h0000_0004, 4'b0001);

      // Internal ops with flags preset to 0110: flags must hold
      dstep("pre",  5'd4,  32'h7F00_0000, 32'h0F00_1000, 1'b0, 32'h8E00_1000, 4'b0110);
      dstep("bm4",  5'd19, 32'h0000_0000, 32'h0000_000A, 1'b1, 32'h0000_0006, 4'b0110);
      dstep("am4",  5'd20, 32'h0000_000A, 32'h0000_0000, 1'b1, 32'h0000_0006, 4'b0110);
      dstep("abp4", 5'd18, 32'h1234_4567, 32'hF000_FE18, 1'b0, 32'h0235_4383, 4'b0110);
      dstep("pa",   5'd25, 32'hCAFE_F00D, 32'h1111_1111, 1'b0, 32'hCAFE_F00D, 4'b0110);
      dstep("bm4w", 5'd19, 32'h0000_0000, 32'h0000_0002, 1'b0, 32'hFFFF_FFFE, 4'b0110);
      dstep("bp4w", 5'd17, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 4'b0110);
      dstep("undf", 5'd23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'b0110);
      dstep("und1f",5'd31, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110);

      // Reset asserted between edges clears immediately
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst.R", R, 32'd0);
      check("arst.FLAG", {28'd0, FLAG}, 32'd0);
      m_flag = 4'd0;
      @(negedge clk);
      reset_n = 1'b1;
      dstep("post", 5'd15, 32'h0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b0101);

      // Back-to-back randomized ops, one check pair per edge
      for (int i = 0; i < 600; i++) begin
         step("rnd", 5'($urandom_range(0, 31)), pick_operand(), pick_operand(),
              1'($urandom()));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
